// File: rtl/joltage_parity_stepper_if.sv
// Handshake/bus bundle for joltage_parity_stepper: target load, per-round
// parity/subtraction exchange, and terminal result.
interface joltage_parity_stepper_if #(
  parameter int unsigned MACHINE_COUNT    = 10,
  parameter int unsigned BITS_PER_JOLTAGE = 9,
  parameter int unsigned LEVEL_WIDTH      = 4
);
  localparam int unsigned BUS_W = MACHINE_COUNT * BITS_PER_JOLTAGE;

  logic                     load_valid;
  logic                     load_ready;
  logic [BUS_W-1:0]         flattened_target;
  logic [MACHINE_COUNT-1:0] parity;
  logic                     parity_valid;
  logic                     sub_valid;
  logic                     sub_ready;
  logic [BUS_W-1:0]         flattened_sub;
  logic [BUS_W-1:0]         work;
  logic [LEVEL_WIDTH-1:0]   level;
  logic                     result_valid;
  logic                     result_ready;
  logic                     result_error;
  logic [MACHINE_COUNT-1:0] error_mask;
  logic                     abort;

  // Driver side: loader, button-selection logic and result consumer.
  modport master (
    output load_valid, flattened_target, sub_valid, flattened_sub,
           result_ready, abort,
    input  load_ready, parity, parity_valid, sub_ready, work, level,
           result_valid, result_error, error_mask
  );

  // Stepper side.
  modport slave (
    input  load_valid, flattened_target, sub_valid, flattened_sub,
           result_ready, abort,
    output load_ready, parity, parity_valid, sub_ready, work, level,
           result_valid, result_error, error_mask
  );
endinterface

// File: rtl/joltage_parity_stepper.sv
// Round-based parity/halving reducer for the joltage-counter solver.
// Each round: present lane parities, accept a subtraction vector, subtract,
// halve, and count rounds until all lanes are zero or a lane goes invalid.
// Optional feature macro: JOLTAGE_PARITY_ODD_CHECK_EN (odd post-subtraction
// lane is an error instead of silently dropping bit 0 in the halving shift).
module joltage_parity_stepper #(
  parameter int unsigned MACHINE_COUNT    = 10,
  parameter int unsigned BITS_PER_JOLTAGE = 9,
  parameter int unsigned LEVEL_WIDTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  joltage_parity_stepper_if.slave bus
);
  localparam int unsigned LANE_W = BITS_PER_JOLTAGE;
  localparam int unsigned DIFF_W = LANE_W + 1;
  localparam int unsigned BUS_W  = MACHINE_COUNT * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRESENT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                   state;
  logic [BUS_W-1:0]         work_q;
  logic [LEVEL_WIDTH-1:0]   level_q;
  logic [MACHINE_COUNT-1:0] error_mask_q;

  logic [DIFF_W-1:0]        diff_c [MACHINE_COUNT];
  logic [MACHINE_COUNT-1:0] underflow_c;
  logic [MACHINE_COUNT-1:0] lane_zero_c;
  logic [BUS_W-1:0]         halved_c;
  logic [LEVEL_WIDTH-1:0]   level_inc_c;
`ifdef JOLTAGE_PARITY_ODD_CHECK_EN
  logic [MACHINE_COUNT-1:0] odd_c;
`endif

  // Per-lane borrow-extended subtraction, halving and zero detect.
  for (genvar i = 0; i < int'(MACHINE_COUNT); i++) begin : g_lane
    assign diff_c[i] = {1'b0, work_q[i*LANE_W +: LANE_W]}
                     - {1'b0, bus.flattened_sub[i*LANE_W +: LANE_W]};
    // Borrow out of the widened difference means sub > work.
    assign underflow_c[i] = diff_c[i][LANE_W];
    assign halved_c[i*LANE_W +: LANE_W] = LANE_W'(diff_c[i] >> 1);
    assign lane_zero_c[i] = (work_q[i*LANE_W +: LANE_W] == '0);
    assign bus.parity[i]  = work_q[i*LANE_W];
`ifdef JOLTAGE_PARITY_ODD_CHECK_EN
    assign odd_c[i] = diff_c[i][0];
`endif
  end

  // Round counter saturates at all-ones.
  assign level_inc_c = (level_q == '1) ? level_q : level_q + LEVEL_WIDTH'(1);

  // Outputs decode straight from state and working registers.
  assign bus.load_ready   = (state == ST_IDLE);
  assign bus.parity_valid = (state == ST_PRESENT);
  assign bus.sub_ready    = (state == ST_PRESENT);
  assign bus.result_valid = (state == ST_DONE) || (state == ST_ERROR);
  assign bus.result_error = (state == ST_ERROR);
  assign bus.work         = work_q;
  assign bus.level        = level_q;
  assign bus.error_mask   = error_mask_q;

  // Control FSM and working registers; abort overrides all transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      work_q       <= '0;
      level_q      <= '0;
      error_mask_q <= '0;
    end else if (bus.abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load_valid) begin
            work_q       <= bus.flattened_target;
            level_q      <= '0;
            error_mask_q <= '0;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          state <= (&lane_zero_c) ? ST_DONE : ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.sub_valid) begin
            if (|underflow_c) begin
              error_mask_q <= underflow_c;
              state        <= ST_ERROR;
            end
`ifdef JOLTAGE_PARITY_ODD_CHECK_EN
            else if (|odd_c) begin
              error_mask_q <= odd_c;
              state        <= ST_ERROR;
            end
`endif
            else begin
              work_q  <= halved_c;
              level_q <= level_inc_c;
              state   <= ST_CHECK;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (bus.result_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_joltage_parity_stepper.sv
// Self-checking bench for joltage_parity_stepper (2 lanes x 9 bits):
// directed scenarios followed by randomized runs against a lane-value model.
module tb_joltage_parity_stepper;
  localparam int unsigned MC = 2;
  localparam int unsigned BW = 9;
  localparam int unsigned LW = 4;

  // Model states (behavioural, independent of the design encoding).
  localparam int M_IDLE = 0, M_PRESENT = 1, M_DONE = 2, M_ERROR = 3, M_BUSY = 4;

  logic clk;
  logic rst_n;

  joltage_parity_stepper_if #(.MACHINE_COUNT(MC), .BITS_PER_JOLTAGE(BW),
                              .LEVEL_WIDTH(LW)) bus ();

  joltage_parity_stepper #(.MACHINE_COUNT(MC), .BITS_PER_JOLTAGE(BW),
                           .LEVEL_WIDTH(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integer lane values.
  int mw[2];
  int mlvl;
  int mmask;
  int mstate;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [17:0] ew;
    ew = {9'(mw[1]), 9'(mw[0])};
    chk({tag, ".load_ready"},   32'(bus.load_ready),   32'(mstate == M_IDLE));
    chk({tag, ".parity_valid"}, 32'(bus.parity_valid), 32'(mstate == M_PRESENT));
    chk({tag, ".sub_ready"},    32'(bus.sub_ready),    32'(mstate == M_PRESENT));
    chk({tag, ".result_valid"}, 32'(bus.result_valid),
        32'(mstate == M_DONE || mstate == M_ERROR));
    chk({tag, ".result_error"}, 32'(bus.result_error), 32'(mstate == M_ERROR));
    chk({tag, ".work"},         32'(bus.work),         32'(ew));
    chk({tag, ".level"},        32'(bus.level),        32'(mlvl));
    chk({tag, ".error_mask"},   32'(bus.error_mask),   32'(mmask));
    chk({tag, ".parity"},       32'(bus.parity),
        32'(((mw[1] & 1) << 1) | (mw[0] & 1)));
  endtask

  // Model: a load always lands in the one-cycle check step.
  task automatic m_load(input int t1, input int t0);
    mw[0] = t0; mw[1] = t1; mlvl = 0; mmask = 0; mstate = M_BUSY;
  endtask

  task automatic m_check();
    mstate = (mw[0] == 0 && mw[1] == 0) ? M_DONE : M_PRESENT;
  endtask

  task automatic m_sub(input int s1, input int s0);
    int um, om, d0, d1;
    um = ((s0 > mw[0]) ? 1 : 0) | ((s1 > mw[1]) ? 2 : 0);
    if (um != 0) begin
      mmask = um; mstate = M_ERROR;
      return;
    end
    d0 = mw[0] - s0;
    d1 = mw[1] - s1;
    om = (d0 & 1) | ((d1 & 1) << 1);
`ifdef JOLTAGE_PARITY_ODD_CHECK_EN
    if (om != 0) begin
      mmask = om; mstate = M_ERROR;
      return;
    end
`else
    if (om != 0) om = 0;
`endif
    mw[0] = d0 / 2;
    mw[1] = d1 / 2;
    mlvl  = (mlvl < 15) ? mlvl + 1 : 15;
    mstate = M_BUSY;
  endtask

  task automatic do_load(input int t1, input int t0, input string tag);
    bus.flattened_target = {9'(t1), 9'(t0)};
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    m_load(t1, t0);
    check_all({tag, ".chk"});
    tick();
    m_check();
    check_all({tag, ".post"});
  endtask

  task automatic do_sub(input int s1, input int s0, input string tag);
    bus.flattened_sub = {9'(s1), 9'(s0)};
    bus.sub_valid = 1'b1;
    tick();
    bus.sub_valid = 1'b0;
    m_sub(s1, s0);
    check_all({tag, ".n1"});
    if (mstate == M_BUSY) begin
      tick();
      m_check();
      check_all({tag, ".n2"});
    end
  endtask

  task automatic do_ack(input string tag);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    mstate = M_IDLE;
    check_all({tag, ".ack"});
  endtask

  // Pick a subtraction amount for one lane: mostly legal and even-leaving,
  // occasionally underflowing or leaving an odd difference.
  function automatic int pick_sub(input int w);
    int r, s;
    r = int'($urandom_range(0, 15));
    if (r == 0 && w < 511) return int'($urandom_range(w + 1, 511));
    s = int'($urandom_range(0, w));
    if (r == 1 && w > 0) begin
      if (((w - s) & 1) == 0) s = (s == 0) ? 1 : s - 1;
      return s;
    end
    if (((w - s) & 1) != 0) s = (s > 0) ? s - 1 : s + 1;
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.flattened_target = '0;
    bus.sub_valid = 1'b0;
    bus.flattened_sub = '0;
    bus.result_ready = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b0;
    mw[0] = 0; mw[1] = 0; mlvl = 0; mmask = 0; mstate = M_IDLE;
    #3;
    check_all("reset");
    #4 rst_n = 1'b1;
    tick();
    check_all("idle");

    // 1. Nominal run
    do_load(3, 4, "t1.load");
    chk("t1.parity0", 32'(bus.parity), 32'h2);
    do_sub(1, 0, "t1.s1");
    chk("t1.work1", 32'(bus.work), 32'({9'd1, 9'd2}));
    chk("t1.level1", 32'(bus.level), 32'd1);
    chk("t1.parity1", 32'(bus.parity), 32'h2);
    do_sub(1, 0, "t1.s2");
    chk("t1.parity2", 32'(bus.parity), 32'h1);
    do_sub(0, 1, "t1.s3");
    chk("t1.rv", 32'(bus.result_valid), 32'd1);
    chk("t1.re", 32'(bus.result_error), 32'd0);
    chk("t1.level", 32'(bus.level), 32'd3);
    do_ack("t1");

    // 2. Underflow
    do_load(0, 2, "t2.load");
    do_sub(1, 0, "t2.s");
    chk("t2.re", 32'(bus.result_error), 32'd1);
    chk("t2.mask", 32'(bus.error_mask), 32'h2);
    chk("t2.work", 32'(bus.work), 32'({9'd0, 9'd2}));
    chk("t2.level", 32'(bus.level), 32'd0);
    do_ack("t2");

    // 3. Odd lane
    do_load(0, 3, "t3.load");
    do_sub(0, 0, "t3.s");
`ifdef JOLTAGE_PARITY_ODD_CHECK_EN
    chk("t3.re", 32'(bus.result_error), 32'd1);
    chk("t3.mask", 32'(bus.error_mask), 32'h1);
    do_ack("t3");
`else
    chk("t3.work", 32'(bus.work), 32'({9'd0, 9'd1}));
    chk("t3.level", 32'(bus.level), 32'd1);
    chk("t3.parity", 32'(bus.parity), 32'h1);
    do_sub(0, 1, "t3.s2");
    do_ack("t3");
`endif

    // 4. Zero target, result held while consumer stalls
    do_load(0, 0, "t4.load");
    chk("t4.rv", 32'(bus.result_valid), 32'd1);
    chk("t4.level", 32'(bus.level), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("t4.hold%0d", i));
    end
    do_ack("t4");

    // 5a. Abort while presenting, then a normal run
    do_load(5, 6, "t5.load");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    mstate = M_IDLE;
    check_all("t5.abort");
    do_load(2, 2, "t5.reload");
    do_sub(0, 0, "t5.s1");
    do_sub(1, 1, "t5.s2");
    chk("t5.done", 32'(bus.result_valid), 32'd1);
    do_ack("t5");

    // 5b. Asynchronous reset mid-round
    do_load(7, 9, "t5r.load");
    do_sub(1, 1, "t5r.s1");
    #2 rst_n = 1'b0;
    #1;
    mw[0] = 0; mw[1] = 0; mlvl = 0; mmask = 0; mstate = M_IDLE;
    check_all("t5r.reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_all("t5r.release");

    // 6. Stall with sub_valid low, then ignored sub in DONE
    do_load(1, 2, "t6.load");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("t6.stall%0d", i));
    end
    do_sub(1, 0, "t6.s1");
    do_sub(0, 1, "t6.s2");
    bus.flattened_sub = {9'd5, 9'd5};
    bus.sub_valid = 1'b1;
    tick();
    bus.sub_valid = 1'b0;
    check_all("t6.ignored_sub");
    do_ack("t6");

    // Randomized runs
    for (int run = 0; run < 30; run++) begin
      int t0, t1;
      t0 = int'($urandom_range(0, 511));
      t1 = (run % 5 == 0) ? 0 : int'($urandom_range(0, 511));
      do_load(t1, t0, $sformatf("r%0d.load", run));
      for (int k = 0; k < 20 && mstate == M_PRESENT; k++) begin
        int s0, s1;
        s0 = pick_sub(mw[0]);
        s1 = pick_sub(mw[1]);
        do_sub(s1, s0, $sformatf("r%0d.s%0d", run, k));
      end
      if (mstate == M_PRESENT) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        mstate = M_IDLE;
        check_all($sformatf("r%0d.abort", run));
      end else begin
        do_ack($sformatf("r%0d", run));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
